// File: rtl/occ_rom_arbiter_pkg.sv
// Shared accelerator constants for the rom_Occ arbiter and its requesters.
// Requester index constants name the Occ-fetch stages that share the ROM.
package accel_pkg;

   localparam int OCC_ADDR_W  = 8;
   localparam int OCC_DATA_W  = 32;
   localparam int OCC_ROM_LAT = 1;

   localparam int OCC_REQ_DATA2 = 0;
   localparam int OCC_REQ_DATA3 = 1;

   // Requester id width; a lone requester still needs a 1-bit id field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/occ_rom_arbiter_if.sv
// Requester-side bus of the rom_Occ arbiter: requests, addresses, grants and returned words.
// master = requester side, slave = arbiter side.
interface occ_rom_arbiter_if
   import accel_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = OCC_ADDR_W,
   parameter int DATA_W = OCC_DATA_W
);
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ*ADDR_W-1:0] addr_i;
   logic [N_REQ-1:0]        gnt_o;
   logic [N_REQ-1:0]        rvalid_o;
   logic [DATA_W-1:0]       rdata_o;

   modport master (
      output req_i, addr_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/occ_rom_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping modulo N_REQ.
// Outputs a one-hot grant and the encoded winner index.
module rr_arbiter
   import accel_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W:0] cand;
   logic           found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
         if (cand >= (IDX_W + 1)'(N_REQ)) begin
            cand = cand - (IDX_W + 1)'(N_REQ);
         end
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found                   = 1'b1;
            gnt_o[cand[IDX_W-1:0]]  = 1'b1;
            idx_o                   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares the single-port rom_Occ between fetch stages: round-robin grant, registered ROM
// command, and a tag pipeline that steers each returned word to the requester that issued it.
module occ_rom_arbiter
   import accel_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = OCC_ADDR_W,
   parameter int DATA_W  = OCC_DATA_W,
   parameter int ROM_LAT = OCC_ROM_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   occ_rom_arbiter_if.slave  bus,
   output logic              busy_o,
   output logic              ce_rom_Occ_o,
   output logic [ADDR_W-1:0] addr_rom_Occ_o,
   input  logic [DATA_W-1:0] data_1_i
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam int DEPTH = ROM_LAT + 1;

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [N_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              accept;
   logic [ADDR_W-1:0] addr_slice [N_REQ];
   logic [ADDR_W-1:0] addr_sel;

   logic              ce_q;
   logic [ADDR_W-1:0] addr_q;
   logic              tag_vld_q [DEPTH];
   logic [IDX_W-1:0]  tag_id_q  [DEPTH];
   logic [N_REQ-1:0]  rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [N_REQ-1:0]  ret_onehot;
   logic              any_tag;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req_i (bus.req_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // Grant is forced low while reset is held so nothing is accepted during reset.
   assign bus.gnt_o = rst_n ? arb_gnt : '0;
   assign accept    = rst_n & (|arb_gnt);

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr_slice
      assign addr_slice[gi] = bus.addr_i[gi*ADDR_W +: ADDR_W];
   end
   assign addr_sel = addr_slice[arb_idx];

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         ce_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         ce_q  <= accept;
         if (accept) begin
            addr_q <= addr_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q[0] <= 1'b0;
         tag_id_q[0]  <= '0;
      end else begin
         tag_vld_q[0] <= accept;
         tag_id_q[0]  <= arb_idx;
      end
   end

   // Tags advance every cycle in lockstep with the ROM's fixed read latency.
   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag_pipe
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tag_vld_q[gi] <= 1'b0;
            tag_id_q[gi]  <= '0;
         end else begin
            tag_vld_q[gi] <= tag_vld_q[gi-1];
            tag_id_q[gi]  <= tag_id_q[gi-1];
         end
      end
   end

   always_comb begin
      ret_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         ret_onehot[k] = (tag_id_q[DEPTH-1] == IDX_W'(k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else if (tag_vld_q[DEPTH-1]) begin
         rvalid_q <= ret_onehot;
         rdata_q  <= data_1_i;
      end else begin
         rvalid_q <= '0;
      end
   end

   always_comb begin
      any_tag = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_tag = any_tag | tag_vld_q[i];
      end
   end

   assign busy_o         = ce_q | any_tag | (|rvalid_q);
   assign ce_rom_Occ_o   = ce_q;
   assign addr_rom_Occ_o = addr_q;
   assign bus.rvalid_o   = rvalid_q;
   assign bus.rdata_o    = rdata_q;

endmodule

// File: doc/occ_rom_arbiter.md
Name: occ_rom_arbiter

Overview:
Shares the single-port rom_Occ between the Occ-fetch stages, get_data_2 and get_data_3, plus any later requester. Uses a round-robin arbiter and a registered ROM command stage. A tag pipeline routes each returned word back to the requester that issued it. This replaces the state-based mux on ce_rom_Occ_o / addr1_rom_Occ_o, so fetch stages can overlap instead of being serialised by the FSM state.

Parameters:
N_REQ, 2, number of requesters (1..8)
ADDR_W, 8, rom_Occ address width
DATA_W, 32, rom_Occ data width
ROM_LAT, 1, cycles from ce/addr at the ROM to valid data_1_i (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  N_REQ  request per requester; held high until granted
addr_i  in  N_REQ*ADDR_W  request address, slice k belongs to requester k
gnt_o  out  N_REQ  one-hot grant, combinational; request accepted when req_i[k]&gnt_o[k]
rvalid_o  out  N_REQ  one-hot, one-cycle pulse: rdata_o belongs to requester k
rdata_o  out  DATA_W  returned Occ word, registered
busy_o  out  1  any request in flight (command stage or tag pipeline)
ce_rom_Occ_o  out  1  rom_Occ chip enable, registered
addr_rom_Occ_o  out  ADDR_W  rom_Occ address, registered
data_1_i  in  DATA_W  rom_Occ read data

Behaviour:
- One clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values:
  - gnt_o is 0 while rst_n is low.
  - rvalid_o=0, rdata_o=0, ce_rom_Occ_o=0, addr_rom_Occ_o=0, busy_o=0.
  - Priority pointer = 0. Tag pipeline cleared.
- Arbitration, combinational:
  - Search req_i from index ptr upward, wrapping modulo N_REQ.
  - The first set bit wins. At most one grant per cycle; one accept per cycle max (ROM throughput 1/cycle).
- Pointer update: on accept of k, ptr <= (k+1) mod N_REQ. With no accept, ptr holds.
- Command stage: on accept in cycle t:
  - At edge t→t+1: ce_rom_Occ_o<=1, addr_rom_Occ_o<=addr_i slice k.
  - With no accept: ce_rom_Occ_o<=0 and addr_rom_Occ_o holds its value.
- Tag pipeline:
  - Depth ROM_LAT+1. Each entry is {valid, id[$clog2(N_REQ) bits, min 1]}.
  - Entry 0 is loaded alongside the command stage. Entries shift every cycle; there is no stall.
- Return: when the last tag entry is valid with id k:
  - rdata_o<=data_1_i and rvalid_o<=one-hot(k) at the next edge.
  - Otherwise rvalid_o<=0 and rdata_o holds.
- Latency: accept in cycle t gives rvalid in cycle t+ROM_LAT+2 (t+3 at default).
- Back-to-back: a new accept is allowed every cycle. Returns come back in issue order.
- busy_o = ce_rom_Occ_o OR any valid tag OR any rvalid_o bit.
- Boundaries:
  - No request: no grant, ptr unchanged.
  - All requesting: strict rotation 0,1,...,N_REQ-1,0.
  - Single requester with continuous req: granted every cycle.
  - A requester that drops req before grant: legal. Nothing is issued for it and no state changes.
  - A requester that changes addr while waiting: the address sampled is the one in the accept cycle.
  - rst_n asserted mid-flight: every in-flight tag is discarded and no rvalid pulse follows. The first grant after release goes to the lowest requesting index.
  - N_REQ=1: grant = req_i, pointer stays 0.

Decomposition:
- Shared package accel_pkg holds:
  - OCC_ADDR_W=8, OCC_DATA_W=32, OCC_ROM_LAT=1.
  - Requester index constants OCC_REQ_DATA2=0, OCC_REQ_DATA3=1.
- One sub-module, rr_arbiter: req, ptr in, one-hot gnt and encoded index out; purely combinational.
- The tag pipeline and command register stay in occ_rom_arbiter.

Test Plan:
- Reset, then a single req_i=2'b01, addr 8'h12, ROM model returns 32'hA5A5_0012 → ce/addr 8'h12 at t+1; rvalid_o=2'b01 with rdata_o=32'hA5A5_0012 at t+3; busy_o low at t+4.
- Both requesters high for 6 cycles, addrs 8'h10/8'h20 → grants alternate 01,10,01,10,01,10; rvalid tags and data return in the same order, each 3 cycles after its accept.
- req_i[1] alone for 4 consecutive cycles with addrs 1,2,3,4 → four grants and four rvalid_o=2'b10 pulses in cycles t+3..t+6, with data for addrs 1..4 in order.
- Accepts at t and t+1, then rst_n pulsed low at t+2 → no rvalid_o pulses afterwards; after release, req_i=2'b11 gets gnt_o=2'b01 first.
- ROM_LAT=3 build, single accept at t → ce at t+1, rvalid at t+5; back-to-back accepts keep full 1/cycle throughput.
- req_i[0] raised then dropped before grant while req_i[1] holds the grant → no ROM access ever issued for requester 0, ptr advances only on actual accepts.
